// File: rtl/mux16bit8way_arbiter.sv
// Round-robin arbiter sharing an 8-way WIDTH-bit mux into one registered valid/ready stage (ARB_LOCK_EN adds burst lock).
// Latency: gnt in the request cycle, out/out_valid one edge later; one word per cycle, no bubble.
// Backpressure: out_valid && !out_ready holds out/sel, forces gnt=0 and freezes arbitration state.
module mux16bit8way_arbiter #(
   parameter int WIDTH     = 16,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  logic [7:0]       req,
`ifdef ARB_LOCK_EN
   input  logic [7:0]       lock,
`endif
   output logic [7:0]       gnt,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       sel
);

   if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("MAX_BURST must be at least 1");
   end

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word [8];
   logic [2:0]       last_q;
   logic [2:0]       rr_win;
   logic [2:0]       rr_idx;
   logic             rr_found;
   logic [2:0]       win;
   logic             load;

   always_comb begin
      word[0] = a;
      word[1] = b;
      word[2] = c;
      word[3] = d;
      word[4] = e;
      word[5] = f;
      word[6] = g;
      word[7] = h;
   end

   assign out_valid = (state_q == FULL);
   assign load      = rst_n && (|req) && (!out_valid || out_ready);
   assign gnt       = load ? (8'd1 << win) : 8'd0;

   // Scan starts just past the previous winner so it lands last in the order.
   always_comb begin
      rr_win   = last_q;
      rr_idx   = 3'd0;
      rr_found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         rr_idx = last_q + 3'(k);
         if (!rr_found && req[rr_idx]) begin
            rr_win   = rr_idx;
            rr_found = 1'b1;
         end
      end
   end

`ifdef ARB_LOCK_EN
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [CW-1:0] burst_q;
   logic [CW-1:0] burst_eff;
   logic          hold_hit;
   logic          burst_more;

   // A nonzero count means the previous owner may keep the mux while it holds req and lock.
   assign hold_hit   = (burst_q != '0) && req[last_q] && lock[last_q];
   assign win        = hold_hit ? last_q : rr_win;
   assign burst_eff  = hold_hit ? burst_q : '0;
   assign burst_more = lock[win] && ((int'(burst_eff) + 1) < MAX_BURST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_q <= '0;
      end else if (load) begin
         burst_q <= burst_more ? (burst_eff + 1'b1) : '0;
      end
   end
`else
   assign win = rr_win;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (load) state_d = FULL;
         FULL:    if (out_ready && !load) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out    <= '0;
         sel    <= 3'd0;
         last_q <= 3'd7;
      end else if (load) begin
         out    <= word[win];
         sel    <= win;
         last_q <= win;
      end
   end

endmodule

// File: tb/tb_mux16bit8way_arbiter.sv
// Directed + random bench for mux16bit8way_arbiter against a queue-free rule-level reference model.
`timescale 1ns/1ps
module tb_mux16bit8way_arbiter;
   localparam int WIDTH     = 16;
   localparam int MAX_BURST = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] w [8];
   logic [7:0]  req;
   logic        out_ready;
   logic [7:0]  gnt;
   logic [15:0] out;
   logic        out_valid;
   logic [2:0]  sel;
`ifdef ARB_LOCK_EN
   logic [7:0]  lock;
`endif

   int checks = 0;
   int errors = 0;

   int          m_last;
   bit          m_valid;
   logic [15:0] m_out;
   int          m_sel;
   int          m_streak;

   always #5 clk = ~clk;

   mux16bit8way_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .a(w[0]), .b(w[1]), .c(w[2]), .d(w[3]),
      .e(w[4]), .f(w[5]), .g(w[6]), .h(w[7]),
      .req(req),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt(gnt), .out(out), .out_valid(out_valid),
      .out_ready(out_ready), .sel(sel)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last   = 7;
      m_valid  = 1'b0;
      m_out    = 16'h0000;
      m_sel    = 0;
      m_streak = 0;
   endtask

   // Index of the requester that should load this cycle, or -1 when nothing loads.
   function automatic int model_win();
      if (req == 8'h00 || (m_valid && !out_ready)) return -1;
`ifdef ARB_LOCK_EN
      if (m_streak > 0 && req[m_last] && lock[m_last]) return m_last;
`endif
      for (int k = 1; k <= 8; k++) begin
         if (req[(m_last + k) % 8]) return (m_last + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_edge(input int win);
      if (win >= 0) begin
`ifdef ARB_LOCK_EN
         if (lock[win]) begin
            m_streak = (win == m_last && m_streak > 0) ? m_streak + 1 : 1;
            if (m_streak >= MAX_BURST) m_streak = 0;
         end else begin
            m_streak = 0;
         end
`endif
         m_out   = w[win];
         m_sel   = win;
         m_last  = win;
         m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // Entered just after a falling edge with inputs already driven; returns on the next falling edge.
   task automatic step(input string tag);
      int         win;
      logic [7:0] eg;
      #1;
      win = model_win();
      eg  = (win < 0) ? 8'h00 : 8'(1 << win);
      check({tag, ".gnt"}, 32'(gnt), 32'(eg));
      @(posedge clk);
      model_edge(win);
      @(negedge clk);
      check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".out"},   32'(out),       32'(m_out));
      check({tag, ".sel"},   32'(sel),       32'(m_sel));
   endtask

   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, ".rst_valid"}, 32'(out_valid), 32'(0));
      check({tag, ".rst_out"},   32'(out),       32'(0));
      check({tag, ".rst_sel"},   32'(sel),       32'(0));
      check({tag, ".rst_gnt"},   32'(gnt),       32'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 8'($urandom);
      out_ready = 1'($urandom);
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
`ifdef ARB_LOCK_EN
      lock = 8'h00;
`endif
      model_reset();
      #1;
      check("reset.gnt",   32'(gnt),       32'(0));
      check("reset.out",   32'(out),       32'(0));
      check("reset.valid", 32'(out_valid), 32'(0));
      check("reset.sel",   32'(sel),       32'(0));
      @(posedge clk);
      @(negedge clk);
      check("reset_hold.valid", 32'(out_valid), 32'(0));
      rst_n = 1'b1;

      // First load after reset goes to a.
      req       = 8'hFF;
      out_ready = 1'b1;
      #1;
      check("t1.gnt_a", 32'(gnt), 32'h01);
      step("t1");

      // Single requester b.
      req  = 8'h02;
      w[1] = 16'h2222;
      #1;
      check("t2.gnt_b", 32'(gnt), 32'h02);
      step("t2");
      check("t2.out",   32'(out),       32'h2222);
      check("t2.sel",   32'(sel),       32'h1);
      check("t2.valid", 32'(out_valid), 32'h1);

      // Fairness: all requesting, words come out a..h then a again.
      pulse_reset("t3");
      for (int i = 0; i < 8; i++) w[i] = 16'(16'h1111 * (i + 1));
      req       = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step("t3");
         check("t3.order", 32'(out), 32'(16'h1111 * ((k % 8) + 1)));
      end

      // Backpressure while holding 3333.
      pulse_reset("t4");
      req  = 8'h04;
      w[2] = 16'h3333;
      step("t4.load");
      check("t4.loaded", 32'(out), 32'h3333);
      req       = 8'hFF;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step("t4.stall");
         check("t4.stall_out", 32'(out), 32'h3333);
         check("t4.stall_sel", 32'(sel), 32'h2);
      end
      out_ready = 1'b1;
      #1;
      check("t4.resume_gnt", 32'(gnt), 32'h08);
      step("t4.resume");
      check("t4.resume_out", 32'(out), 32'h4444);

      // Reset while a word is held: dropped at once, order restarts at a.
      check("t5.pre_valid", 32'(out_valid), 32'h1);
      pulse_reset("t5");
      req = 8'hFF;
      #1;
      check("t5.restart_gnt", 32'(gnt), 32'h01);
      step("t5");

      // Random traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         req       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
`ifdef ARB_LOCK_EN
         lock = 8'($urandom) | 8'($urandom);
`endif
         if ($urandom_range(0, 49) == 0) pulse_reset("rnd");
         step("rnd");
      end

`ifdef ARB_LOCK_EN
      begin
         int exp_seq [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
         pulse_reset("t6");
         lock      = 8'h01;
         req       = 8'h05;
         out_ready = 1'b1;
         for (int k = 0; k < 10; k++) begin
            step("t6");
            check("t6.burst_sel", 32'(sel), 32'(exp_seq[k]));
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
